pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, replacing fixed enable/flush latches between pipeline stages of the processor. Holds up to two beats, so upstream stalls are absorbed without a combinational ready path. It supports flush-to-bubble, a sticky halt that blocks further intake, and a saturating stall counter for performance analysis.

## Interface
- DATA_W, 64: payload width in bits; the payload is the concatenation of all stage fields.
- CNT_W, 16: width of the stall counter.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  discard all held beats and clear the halt state.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  beat carries a halt marker.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts a beat.
- out_data  out  DATA_W  downstream payload.
- out_halt  out  1  halt marker of the output beat.
- occupancy  out  2  number of held beats, 0 to 2.
- halted  out  1  a halt beat has been accepted; intake is blocked.
- stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

## Operation
- Storage: a main register drives out_*, and a skid register holds the second beat. States are EMPTY (0 beats), ONE (main only) and FULL (main and skid).
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- in_ready = !FULL && !halted && !flush.
- EMPTY: on accept, the beat goes to main and the state becomes ONE.
- ONE with emit and no accept: becomes EMPTY.
- ONE with accept and emit: the new beat goes to main and the state stays ONE.
- ONE with accept and no emit: the beat goes to skid and the state becomes FULL.
- FULL with emit: skid moves to main, skid is cleared and the state becomes ONE. No accept is possible in FULL.
- Order is preserved: beats emerge in acceptance order.
- Halt: accepting a beat with in_halt=1 sets halted on the next edge. The halt beat itself still propagates to out_halt. halted stays set until RST or flush.
- Flush has priority over accept, emit and halt.
  - On the next edge, state becomes EMPTY, main and skid data and halt bits are zeroed, and halted clears.
  - in_ready is 0 during the flush cycle, so no beat is accepted.
  - An emit that coincides with flush still counts as consumed downstream. The register contents are discarded regardless.
- stall_cnt increments each cycle in which out_valid && !out_ready. It saturates at 2^CNT_W−1 and clears only on RST; flush does not clear it.
- Cleared bubbles carry all-zero data, so the downstream stage sees no write-enable or halt.

## Timing
- Reset (RST high at an edge) sets the following values on that edge:
  - out_valid=0, out_data=0, out_halt=0.
  - occupancy=0, halted=0, stall_cnt=0.
  - skid contents=0.
  - in_ready is 1 in the following cycle.
- RST asserted mid-transfer drops all held beats. Simultaneous RST and flush behaves as RST.
- Latency: a beat accepted at edge N is presented on out_* after edge N, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1.
- in_ready depends only on registered state and flush, never on out_ready. This holds with the skid buffer enabled.
- out_valid, out_data, out_halt, occupancy, halted and stall_cnt are all registered outputs.
- Stall counter boundary: at saturation, further stall cycles leave the value unchanged; there is no wrap.

## Configuration
- PIPE_STAGE_SKID_EN defined: the two-entry skid behaviour described above. in_ready has no combinational path from out_ready.
- PIPE_STAGE_SKID_EN undefined: single register only.
  - in_ready = (!out_valid || out_ready) && !halted && !flush. This is a combinational path from out_ready.
  - occupancy is at most 1 and the FULL state does not exist.
  - Throughput and latency are unchanged. All other rules, including flush, halt and stall_cnt, are identical.

## Test plan
- Streaming: hold out_ready=1 and send beats 0x1, 0x2, 0x3 back-to-back. Expect out_data 0x1, 0x2, 0x3 on consecutive cycles, one cycle after each accept, with stall_cnt=0.
- Back-pressure: hold out_ready=0 and send 0xA then 0xB.
  - With the macro: occupancy=2, in_ready=0, and a third beat 0xC is not accepted.
  - Release out_ready: expect 0xA, then 0xB, then 0xC is accepted.
  - stall_cnt equals the number of stalled cycles.
- Flush while FULL: assert flush for one cycle. Next cycle expect occupancy=0, out_valid=0 and out_data=0, and that no beat was accepted during the flush cycle.
- Halt: accept 0x5 with in_halt=1. Expect halted=1 next cycle and in_ready=0 thereafter, with out_halt=1 when 0x5 is emitted. After a one-cycle flush, expect halted=0 and in_ready=1.
- Saturation: set CNT_W=4 and hold out_ready=0 with out_valid=1 for 20 cycles. stall_cnt must read 15 and stay at 15.
- Reset mid-operation: in the FULL state, assert RST for one cycle. Expect all outputs 0, then in_ready=1 the following cycle, with the macro both defined and undefined.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-beat valid/ready pipeline register (skid entry when PIPE_STAGE_SKID_EN is defined), with flush, sticky halt and stall counter.
// One-cycle latency, full throughput; in_ready comes from registered state and flush only when the skid is built.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic [1:0]        occupancy,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic              halt;
    logic [DATA_W-1:0] dat;
  } beat_t;

  state_t state;
  beat_t  main_q;
  beat_t  in_beat;
  logic   accept;
  logic   emit;

  assign in_beat   = {in_halt, in_data};
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_data  = main_q.dat;
  assign out_halt  = main_q.halt;
  assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
  beat_t skid_q;
  assign in_ready = (state != FULL) && !halted && !flush;
`else
  assign in_ready = (!out_valid || out_ready) && !halted && !flush;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= EMPTY;
      main_q    <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q    <= '0;
`endif
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      // Flush wins over everything; an emit in the same cycle was already taken downstream.
      if (flush) begin
        state     <= EMPTY;
        main_q    <= '0;
        out_valid <= 1'b0;
        halted    <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_q    <= '0;
`endif
      end else begin
        if (accept && in_halt)
          halted <= 1'b1;

        case (state)
          EMPTY: begin
            if (accept) begin
              main_q    <= in_beat;
              out_valid <= 1'b1;
              state     <= ONE;
            end
          end
          ONE: begin
            if (accept && emit) begin
              main_q <= in_beat;
            end
`ifdef PIPE_STAGE_SKID_EN
            else if (accept) begin
              skid_q <= in_beat;
              state  <= FULL;
            end
`endif
            else if (emit) begin
              main_q    <= '0;
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
`ifdef PIPE_STAGE_SKID_EN
          FULL: begin
            if (emit) begin
              main_q <= skid_q;
              skid_q <= '0;
              state  <= ONE;
            end
          end
`endif
          default: begin
            state <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed plan followed by random traffic, checked by a queue scoreboard.
// Works with PIPE_STAGE_SKID_EN defined or undefined.
module tb_pipe_stage_reg;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_halt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_halt;
  logic [1:0]    occupancy;
  logic          halted;
  logic [CW-1:0] stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .occupancy(occupancy), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          h;
    logic [DW-1:0] d;
  } beat_t;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  logic  halted_m = 1'b0;
  logic  zero_exp = 1'b1;
  logic  mon_en   = 1'b0;
  int    stall_m  = 0;
  logic  pend_acc = 1'b0;
  logic  pend_clr = 1'b0;
  beat_t pend_beat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return (exp_q.size() < 2) && !halted_m && !flush;
`else
    return ((exp_q.size() == 0) || out_ready) && !halted_m && !flush;
`endif
  endfunction

  // Scoreboard monitor: checks held-beat view every cycle, retires a beat on each emit.
  int sz;
  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      sz = exp_q.size();
      chk("out_valid", out_valid, sz > 0);
      chk("occupancy", occupancy, sz);
      chk("halted", halted, halted_m);
      chk("stall_cnt", stall_cnt, stall_m);
      chk("in_ready", in_ready, model_ready());
      if (sz > 0) begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_halt", out_halt, exp_q[0].h);
      end else if (zero_exp) begin
        chk("bubble_data", out_data, '0);
        chk("bubble_halt", out_halt, '0);
      end
      if (RST) begin
        stall_m = 0;
      end else begin
        if (sz > 0 && !out_ready && stall_m < SAT)
          stall_m++;
        if (out_valid && out_ready) begin
          if (sz == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL emit_underflow: got emit, want none at %0t", $time);
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic h,
                       input logic ordy, input logic fl, input logic rs);
    in_valid  = v;
    in_data   = d;
    in_halt   = h;
    out_ready = ordy;
    flush     = fl;
    RST       = rs;
    @(negedge CLK);
    pend_acc    = in_valid && in_ready;
    pend_beat.h = h;
    pend_beat.d = d;
    pend_clr    = fl || rs;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (pend_clr) begin
      exp_q.delete();
      halted_m = 1'b0;
      zero_exp = 1'b1;
    end else if (pend_acc) begin
      exp_q.push_back(pend_beat);
      if (pend_beat.h) halted_m = 1'b1;
      zero_exp = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic h,
                      input logic ordy, input logic fl, input logic rs);
    drive(v, d, h, ordy, fl, rs);
    tick();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic h, input logic ordy);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      drive(1'b1, d, h, ordy, 1'b0, 1'b0);
      done = pend_acc;
      tick();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: beat 0x%0h not accepted, want accepted within 16 cycles", d);
    end
  endtask

  logic          rv, rh, ro, rf, rr;
  logic [DW-1:0] rd;

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_halt = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST    = 1'b0;
    mon_en = 1'b1;

    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    tick();

    // Streaming
    send(64'h1, 1'b0, 1'b1);
    send(64'h2, 1'b0, 1'b1);
    send(64'h3, 1'b0, 1'b1);
    idle(1'b1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stream_stall", stall_cnt, 0);
    tick();

    // Back-pressure
    step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_occupancy", occupancy, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_c_taken", pend_acc, 0);
    tick();
`ifndef PIPE_STAGE_SKID_EN
    send(64'hB, 1'b0, 1'b1);
`endif
    send(64'hC, 1'b0, 1'b1);
    idle(1'b1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_stall", stall_cnt, 2);
    tick();

    // Flush while holding beats
    step(1'b1, 64'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h23, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fl_in_ready", in_ready, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_data", out_data, 0);
    tick();

    // Halt
    send(64'h5, 1'b1, 1'b0);
    drive(1'b1, 64'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_set", halted, 1);
    chk("halt_blocks", in_ready, 0);
    tick();
    drive(1'b1, 64'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_out_halt", out_halt, 1);
    chk("halt_out_data", out_data, 64'h5);
    chk("halt_blocks_emit", in_ready, 0);
    tick();
    drive(1'b1, 64'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_still_blocked", in_ready, 0);
    tick();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_cleared", halted, 0);
    chk("halt_ready", in_ready, 1);
    tick();

    // Stall counter saturation
    send(64'h9, 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_value", stall_cnt, SAT);
    tick();
    idle(1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", stall_cnt, SAT);
    tick();

    // Reset with beats held
    step(1'b1, 64'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_halt", out_halt, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_halted", halted, 0);
    chk("mrst_stall", stall_cnt, 0);
    chk("mrst_in_ready", in_ready, 1);
    tick();

    // Random traffic
    repeat (400) begin
      rv = ($urandom_range(0, 9) < 7);
      rd = {$urandom, $urandom};
      rh = ($urandom_range(0, 29) == 0);
      ro = ($urandom_range(0, 9) < 6);
      rf = ($urandom_range(0, 24) == 0);
      rr = ($urandom_range(0, 149) == 0);
      step(rv, rd, rh, ro, rf, rr);
    end
    repeat (4) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
